// File: rtl/alien_fleet_ctrl.sv
// Fleet controller for one alien row: march direction, step strobe, fleet x-offset and LFSR fire selection.
// Latency: every output is registered; a counter wrap on edge n appears on the outputs after edge n.
// Backpressure: none; enable=0 freezes the counters and the LFSR and suppresses the step/drop/fire pulses.
module alien_fleet_ctrl #(
  parameter int          N_ALIENS    = 8,
  parameter int          XW          = 8,
  parameter int          X_MIN       = 0,
  parameter int          X_MAX       = 15,
  parameter int          STEP_PERIOD = 1000,
  parameter int          FIRE_PERIOD = 1500,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [N_ALIENS-1:0] alive,
  output logic                dir,
  output logic [XW-1:0]       fleet_x,
  output logic                step,
  output logic                drop,
  output logic [N_ALIENS-1:0] fire,
  output logic                wave_clear
);

  localparam int IW = (N_ALIENS > 1) ? $clog2(N_ALIENS) : 1;
  localparam int SW = $clog2(STEP_PERIOD);
  localparam int FW = $clog2(FIRE_PERIOD);

  localparam logic [XW-1:0] XMIN_V = XW'(X_MIN);
  localparam logic [XW-1:0] XMAX_V = XW'(X_MAX);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIOD - 1);
  localparam logic [FW-1:0] FIRE_LAST = FW'(FIRE_PERIOD - 1);

  logic [SW-1:0]       step_cnt;
  logic [FW-1:0]       fire_cnt;
  logic [15:0]         lfsr;
  logic                lfsr_fb;
  logic                step_wrap;
  logic                fire_wrap;
  logic                dir_nxt;
  logic                drop_nxt;
  logic [XW-1:0]       x_nxt;
  logic [N_ALIENS-1:0] fire_sel;
  logic [IW-1:0]       start_idx;
  logic [IW-1:0]       probe_idx;
  logic                found;

  assign step_wrap = enable && (step_cnt == STEP_LAST);
  assign fire_wrap = enable && (fire_cnt == FIRE_LAST);
  // Fibonacci feedback for taps 16,14,13,11 with the register shifting toward bit 0.
  assign lfsr_fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // Next march position: reverse with a drop at either edge, otherwise move one column.
  always_comb begin
    dir_nxt  = dir;
    x_nxt    = fleet_x;
    drop_nxt = 1'b0;
    if (step_wrap) begin
      if (dir && (fleet_x == XMAX_V)) begin
        dir_nxt  = 1'b0;
        drop_nxt = 1'b1;
      end else if (!dir && (fleet_x == XMIN_V)) begin
        dir_nxt  = 1'b1;
        drop_nxt = 1'b1;
      end else if (dir) begin
        x_nxt = fleet_x + XW'(1);
      end else begin
        x_nxt = fleet_x - XW'(1);
      end
    end
  end

  // Shooter pick: first living alien at or above the LFSR start index, wrapping around the row.
  always_comb begin
    start_idx = lfsr[IW-1:0];
    probe_idx = start_idx;
    found     = 1'b0;
    fire_sel  = '0;
    for (int i = 0; i < N_ALIENS; i++) begin
      probe_idx = start_idx + IW'(i);
      if (!found && alive[probe_idx]) begin
        found    = 1'b1;
        fire_sel = N_ALIENS'(1) << probe_idx;
      end
    end
  end

  // Counters, LFSR and registered outputs; pulses last exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt   <= '0;
      fire_cnt   <= '0;
      lfsr       <= LFSR_SEED;
      dir        <= 1'b1;
      fleet_x    <= XMIN_V;
      step       <= 1'b0;
      drop       <= 1'b0;
      fire       <= '0;
      wave_clear <= 1'b0;
    end else begin
      wave_clear <= (alive == '0);
      step       <= step_wrap;
      drop       <= drop_nxt;
      fire       <= fire_wrap ? fire_sel : '0;
      dir        <= dir_nxt;
      fleet_x    <= x_nxt;
      if (enable) begin
        step_cnt <= step_wrap ? '0 : step_cnt + SW'(1);
        fire_cnt <= fire_wrap ? '0 : fire_cnt + FW'(1);
        lfsr     <= {lfsr_fb, lfsr[15:1]};
      end
    end
  end

endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// Bench for alien_fleet_ctrl: scoreboard model derived from step/fire counts plus directed march and corner sequences.
// Latency: outputs are compared 1 ns after each rising edge against the model state for that edge.
// Backpressure: not applicable; enable is driven randomly and in directed freeze windows.
module tb_alien_fleet_ctrl;

  localparam int N    = 8;
  localparam int XMIN = 0;
  localparam int XMAX = 3;
  localparam int SP   = 4;
  localparam int FP   = 6;
  localparam int L    = XMAX - XMIN + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] alive = 8'hFF;
  logic       dir;
  logic [7:0] fleet_x;
  logic       step;
  logic       drop;
  logic [7:0] fire;
  logic       wave_clear;

  alien_fleet_ctrl #(
    .N_ALIENS(N), .XW(8), .X_MIN(XMIN), .X_MAX(XMAX),
    .STEP_PERIOD(SP), .FIRE_PERIOD(FP), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .alive(alive),
    .dir(dir), .fleet_x(fleet_x), .step(step), .drop(drop),
    .fire(fire), .wave_clear(wave_clear)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: position is a pure function of the number of steps taken.
  int         en_cnt;
  int         steps;
  logic [15:0] m_lfsr;
  logic       m_dir, m_step, m_drop, m_wc;
  logic [7:0] m_x, m_fire;

  typedef struct {
    logic       en;
    logic [7:0] alv;
    logic [7:0] x;
    logic       d;
    logic       dr;
  } step_rec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    en_cnt = 0;
    steps  = 0;
    m_lfsr = 16'hACE1;
    m_dir  = 1'b1;
    m_x    = 8'(XMIN);
    m_step = 1'b0;
    m_drop = 1'b0;
    m_fire = 8'h00;
    m_wc   = 1'b0;
  endtask

  task automatic model_edge();
    int   p;
    int   start;
    int   idx;
    bit   hit;
    logic fb;
    m_wc   = (alive == 8'h00);
    m_step = 1'b0;
    m_drop = 1'b0;
    m_fire = 8'h00;
    if (enable) begin
      if (en_cnt % SP == SP - 1) begin
        steps++;
        p      = steps % (2 * L);
        m_step = 1'b1;
        m_x    = 8'(XMIN + ((p < L) ? p : (2 * L - 1 - p)));
        m_dir  = (p < L);
        m_drop = (p == 0) || (p == L);
      end
      if (en_cnt % FP == FP - 1) begin
        start = int'(m_lfsr) % N;
        hit   = 1'b0;
        for (int i = 0; i < N; i++) begin
          idx = (start + i) % N;
          if (!hit && alive[idx]) begin
            hit    = 1'b1;
            m_fire = 8'(1 << idx);
          end
        end
      end
      fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
      m_lfsr = {fb, m_lfsr[15:1]};
      en_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("dir", dir, m_dir);
    chk("fleet_x", fleet_x, m_x);
    chk("step", step, m_step);
    chk("drop", drop, m_drop);
    chk("fire", fire, m_fire);
    chk("wave_clear", wave_clear, m_wc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dir"}, dir, 1'b1);
    chk({tag, "_fleet_x"}, fleet_x, 8'(XMIN));
    chk({tag, "_step"}, step, 1'b0);
    chk({tag, "_drop"}, drop, 1'b0);
    chk({tag, "_fire"}, fire, 8'h00);
    chk({tag, "_wave_clear"}, wave_clear, 1'b0);
  endtask

  initial begin
    step_rec_t tbl[9];
    int        cnt;
    int        gap;
    int        r;

    tbl[0] = '{1'b1, 8'hFF, 8'd1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'hFF, 8'd2, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'hFF, 8'd3, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'hFF, 8'd3, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'hFF, 8'd2, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'hFF, 8'd1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'hFF, 8'd0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 8'hFF, 8'd0, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 8'hFF, 8'd1, 1'b1, 1'b0};

    // Reset held: outputs at reset values.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");

    // Release with the game stopped: nothing moves.
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt += int'(step) + int'(drop) + int'(fire != 8'h00);
    end
    chk("idle_pulses", cnt, 0);
    chk("idle_fleet_x", fleet_x, 8'(XMIN));

    // March through both edges using the step table.
    for (int k = 0; k < 9; k++) begin
      enable = tbl[k].en;
      alive  = tbl[k].alv;
      gap = 0;
      do begin
        tick();
        gap++;
      end while (!step && gap < 8);
      if (!step) begin
        chk("march_timeout", 0, 1);
      end else begin
        chk("march_gap", gap, SP);
        chk("march_x", fleet_x, tbl[k].x);
        chk("march_dir", dir, tbl[k].d);
        chk("march_drop", drop, tbl[k].dr);
      end
    end

    // Fire cadence with a full row: exactly one pulse per fire period.
    cnt = 0;
    for (int i = 0; i < 10 * FP; i++) begin
      tick();
      if (fire != 8'h00) cnt++;
    end
    chk("fire_count_full", cnt, 10);

    // Randomized enable and alive patterns against the model.
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 3);
      case (r)
        0: alive = 8'($urandom);
        1: alive = 8'(1 << $urandom_range(0, 7));
        2: alive = alive;
        default: alive = ($urandom_range(0, 4) == 0) ? 8'h00 : (alive & 8'($urandom));
      endcase
      tick();
    end

    // Single survivor: the search must wrap to reach it from any start.
    enable = 1'b1;
    alive  = 8'h02;
    tick();
    cnt = 0;
    for (int i = 0; i < 4 * FP; i++) begin
      tick();
      if (fire != 8'h00) begin
        cnt++;
        chk("search_02", fire, 8'h02);
      end
    end
    chk("search_02_count", cnt, 4);
    alive = 8'h10;
    tick();
    cnt = 0;
    for (int i = 0; i < 4 * FP; i++) begin
      tick();
      if (fire != 8'h00) begin
        cnt++;
        chk("search_10", fire, 8'h10);
      end
    end
    chk("search_10_count", cnt, 4);

    // Empty wave: flag one cycle later, no shots, march continues.
    alive = 8'hFF;
    tick();
    alive = 8'h00;
    tick();
    chk("wave_clear_rise", wave_clear, 1'b1);
    cnt = 0;
    gap = 0;
    for (int i = 0; i < 3 * FP; i++) begin
      tick();
      if (fire != 8'h00) cnt++;
      if (step) gap++;
    end
    chk("empty_fire", cnt, 0);
    chk("empty_march", (gap >= 4), 1'b1);
    alive = 8'hFF;
    tick();
    chk("wave_clear_fall", wave_clear, 1'b0);

    // Freeze at step_cnt == 2, then the step lands two enabled cycles later.
    cnt = 0;
    while (en_cnt % SP != 2 && cnt < 8) begin
      tick();
      cnt++;
    end
    chk("freeze_align", en_cnt % SP, 2);
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cnt += int'(step) + int'(fire != 8'h00);
    end
    chk("freeze_pulses", cnt, 0);
    enable = 1'b1;
    tick();
    chk("resume_step_early", step, 1'b0);
    tick();
    chk("resume_step", step, 1'b1);

    // Reset asserted during a step cycle clears everything immediately.
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!step && cnt < 8);
    chk("pre_reset_step", step, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3 * FP; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alien_fleet_ctrl.md
Name: alien_fleet_ctrl

Overview:
Fleet-level controller that drives every alien instance in one row. Generates the shared march direction, a periodic step strobe and the fleet x-offset. Selects at most one living alien per fire interval via an LFSR and issues its one-hot fire request. Consumes the alive vector of the row, so each alien's fired output can only follow a request this block made.

Parameters:
N_ALIENS, 8, aliens in the row; power of two, 2..32
XW, 8, width of fleet_x
X_MIN, 0, leftmost legal fleet_x
X_MAX, 15, rightmost legal fleet_x (X_MAX > X_MIN)
STEP_PERIOD, 1000, enabled clk cycles per march step (>= 2)
FIRE_PERIOD, 1500, enabled clk cycles per fire attempt (>= 2)
LFSR_SEED, 16'hACE1, LFSR reset value (non-zero)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  game running; low freezes all counters and the LFSR
alive  in  N_ALIENS  alive flag per alien (bit i = alien i)
dir  out  1  march direction to all aliens: 0 = left, 1 = right
fleet_x  out  XW  current fleet x-offset
step  out  1  one-cycle pulse per march step
drop  out  1  one-cycle pulse, coincident with step, when the fleet reverses at an edge
fire  out  N_ALIENS  one-hot (or zero) one-cycle fire request per alien
wave_clear  out  1  registered level: high while alive == 0

Behaviour:
- Reset (async assert, sync release): dir=1, fleet_x=X_MIN, step=0, drop=0, fire=0, wave_clear=0, step_cnt=0, fire_cnt=0, lfsr=LFSR_SEED.
- All outputs are registered. No combinational path from any input to any output.
- enable=0: step_cnt, fire_cnt and lfsr hold. step, drop and fire are 0 the next cycle. dir and fleet_x hold. wave_clear still tracks alive.
- Step counter: increments on each enabled cycle. When step_cnt == STEP_PERIOD-1, it wraps to 0 and on that same edge:
  - step <= 1.
  - dir=1 and fleet_x == X_MAX: dir <= 0, drop <= 1, fleet_x unchanged.
  - dir=0 and fleet_x == X_MIN: dir <= 1, drop <= 1, fleet_x unchanged.
  - Otherwise: fleet_x <= fleet_x +1 (dir=1) or -1 (dir=0), drop <= 0.
- step and drop are high for exactly one cycle. Updated dir and fleet_x are visible in the same cycle as step. fleet_x never leaves [X_MIN, X_MAX].
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts once per enabled cycle and never reaches 0.
- Fire counter: increments on each enabled cycle and wraps at FIRE_PERIOD-1.
  - On the wrap edge: start = lfsr[log2(N_ALIENS)-1:0] (pre-shift value on that edge).
  - Search alive upward from start, wrapping modulo N_ALIENS; the first set bit k is selected.
  - fire <= one-hot(k) for exactly one cycle.
  - alive == 0: fire stays 0, attempt discarded, no retry until the next wrap.
- fire uses the alive value sampled on the wrap edge. An alien hit on that same edge may still receive a request; the alien gates it with its own alive.
- Step wrap and fire wrap on the same edge: both take effect independently.
- wave_clear <= (alive == 0) every cycle, one-cycle latency. It does not stop marching; the game FSM deasserts enable.
- Reset mid-operation: all state returns to reset values immediately; any pending pulse is dropped.

Test Plan (bench params: N_ALIENS=8, X_MIN=0, X_MAX=3, STEP_PERIOD=4, FIRE_PERIOD=6):
- Reset: hold rst_n=0 → dir=1, fleet_x=0, step=drop=0, fire=8'h00, wave_clear=0. Release with enable=0 for 20 cycles → no pulses, fleet_x=0.
- March: enable=1, alive=8'hFF → step every 4th cycle; fleet_x sequence 1,2,3,3(drop=1, dir=0),2,1,0,0(drop=1, dir=1),1; drop never high without step.
- Fire distribution: alive=8'hFF, 6 cycles → fire one-hot, index == lfsr[2:0] captured at the wrap edge (checked against a model); fire high exactly 1 cycle per 6.
- Search wrap: alive=8'b0000_0010, model start index 5 → fire=8'h02. alive=8'h10 → fire=8'h10 on every attempt.
- Empty wave: alive 8'hFF→8'h00 → wave_clear=1 one cycle later; fire stays 8'h00 across 3 fire periods; marching continues.
- Freeze/reset: drop enable mid-count (step_cnt=2) for 10 cycles, re-enable → next step after 2 more cycles. Assert rst_n during a step cycle → all outputs at reset values the same cycle.
